// File: rtl/pwm_carrier_gen.sv
// Triangle / saw-up / saw-down PWM carrier with prescaler and period-boundary shadow commit.
// Outputs are registered and change on the edge that processes a tick; en=0 freezes counting.
`timescale 1ns/1ps
module pwm_carrier_gen #(
    parameter int N = 12,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         load_i,
    input  logic [1:0]   mode_i,
    input  logic [N-1:0] period_i,
    input  logic [P-1:0] prescale_i,
    output logic [N-1:0] count_o,
    output logic         dir_o,
    output logic         zero_o,
    output logic         peak_o,
    output logic         update_o
);

    typedef enum logic [1:0] {
        MODE_TRI  = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    mode_t        act_mode, sh_mode;
    logic [N-1:0] act_per, sh_per;
    logic [P-1:0] act_pre, sh_pre, pcnt;
    logic         pending;

    logic         tick, boundary, commit;
    logic [N-1:0] nxt_cnt, nxt_per;
    logic         nxt_dir;

    always_comb begin
        tick     = en && (act_mode != MODE_HOLD) && (pcnt == act_pre);
        boundary = 1'b0;
        if (act_per == '0) begin
            boundary = 1'b1;
        end else begin
            case (act_mode)
                // PER==1 reaches 0 from the up direction, so accept either direction there
                MODE_TRI:  boundary = (count_o == N'(1)) && (!dir_o || act_per == N'(1));
                MODE_UP:   boundary = (count_o == act_per);
                MODE_DOWN: boundary = (count_o == '0);
                default:   boundary = 1'b0;
            endcase
        end
        commit = pending && ((tick && boundary) || (en && act_mode == MODE_HOLD));

        nxt_cnt = count_o;
        nxt_dir = dir_o;
        if (tick) begin
            if (act_per == '0) begin
                nxt_cnt = '0;
            end else begin
                case (act_mode)
                    MODE_TRI: begin
                        if (dir_o) begin
                            if (count_o < act_per) begin
                                nxt_cnt = count_o + N'(1);
                            end else begin
                                nxt_cnt = act_per - N'(1);
                                nxt_dir = 1'b0;
                            end
                        end else begin
                            if (count_o != '0) begin
                                nxt_cnt = count_o - N'(1);
                            end else begin
                                nxt_cnt = N'(1);
                                nxt_dir = 1'b1;
                            end
                        end
                    end
                    MODE_UP: begin
                        nxt_cnt = (count_o >= act_per) ? '0 : count_o + N'(1);
                        nxt_dir = 1'b1;
                    end
                    MODE_DOWN: begin
                        nxt_cnt = (count_o == '0) ? act_per : count_o - N'(1);
                        nxt_dir = 1'b0;
                    end
                    default: begin
                        nxt_cnt = count_o;
                        nxt_dir = dir_o;
                    end
                endcase
            end
        end

        nxt_per = act_per;
        if (commit) begin
            nxt_per = sh_per;
            // Committing into hold freezes the carrier where it stands
            case (sh_mode)
                MODE_TRI, MODE_UP: begin
                    nxt_cnt = '0;
                    nxt_dir = 1'b1;
                end
                MODE_DOWN: begin
                    nxt_cnt = sh_per;
                    nxt_dir = 1'b0;
                end
                default: begin
                    nxt_cnt = count_o;
                    nxt_dir = dir_o;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            act_mode <= MODE_TRI;
            act_per  <= '1;
            act_pre  <= '0;
            sh_mode  <= MODE_TRI;
            sh_per   <= '1;
            sh_pre   <= '0;
            pending  <= 1'b0;
            pcnt     <= '0;
            count_o  <= '0;
            dir_o    <= 1'b1;
            zero_o   <= 1'b0;
            peak_o   <= 1'b0;
            update_o <= 1'b0;
        end else begin
            if (commit) begin
                act_mode <= sh_mode;
                act_per  <= sh_per;
                act_pre  <= sh_pre;
                pending  <= 1'b0;
            end
            // A load in the commit cycle refills the slot for the next boundary
            if (load_i) begin
                sh_mode <= mode_t'(mode_i);
                sh_per  <= period_i;
                sh_pre  <= prescale_i;
                pending <= 1'b1;
            end

            if (commit || tick) begin
                pcnt <= '0;
            end else if (en && act_mode != MODE_HOLD) begin
                pcnt <= pcnt + P'(1);
            end

            count_o  <= nxt_cnt;
            dir_o    <= nxt_dir;
            zero_o   <= tick && (nxt_cnt == '0);
            peak_o   <= tick && (nxt_cnt == nxt_per);
            update_o <= commit;
        end
    end

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Self-checking bench for pwm_carrier_gen (N=4): phase-based carrier model plus directed literal checks.
`timescale 1ns/1ps
module tb_pwm_carrier_gen;
    localparam int N = 4;
    localparam int P = 8;
    localparam int PMAX = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         en = 1'b0;
    logic         load_i = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic [N-1:0] period_i = '0;
    logic [P-1:0] prescale_i = '0;
    logic [N-1:0] count_o;
    logic         dir_o, zero_o, peak_o, update_o;

    pwm_carrier_gen #(.N(N), .P(P)) dut (
        .clk(clk), .nrst(nrst), .en(en), .load_i(load_i), .mode_i(mode_i),
        .period_i(period_i), .prescale_i(prescale_i), .count_o(count_o),
        .dir_o(dir_o), .zero_o(zero_o), .peak_o(peak_o), .update_o(update_o)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    bit chk = 1'b0;

    // Model: position within the carrier period is a phase 0..L-1; outputs follow from it.
    int m_mode, m_per, m_pre, s_mode, s_per, s_pre;
    int m_pc, m_ph, m_count;
    bit m_pend, m_fresh, m_dir, m_zero, m_peak, m_upd;

    task automatic derive();
        case (m_mode)
            0: begin
                m_count = (m_ph <= m_per) ? m_ph : 2 * m_per - m_ph;
                if (m_per == 0)     m_dir = 1'b1;
                else if (m_ph == 0) m_dir = m_fresh;
                else                m_dir = (m_ph <= m_per);
            end
            1: begin m_count = m_ph;         m_dir = 1'b1; end
            2: begin m_count = m_per - m_ph; m_dir = 1'b0; end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin : model
        int  len, nph;
        bit  tk, cm;
        if (!nrst) begin
            m_mode = 0; m_per = PMAX; m_pre = 0;
            s_mode = 0; s_per = PMAX; s_pre = 0;
            m_pend = 0; m_pc = 0; m_ph = 0; m_fresh = 1;
            m_count = 0; m_dir = 1; m_zero = 0; m_peak = 0; m_upd = 0;
        end else begin
            tk = en && m_mode != 3 && m_pc == m_pre;
            m_zero = 0; m_peak = 0; m_upd = 0; cm = 0; nph = 0;
            if (tk) begin
                len = (m_per == 0) ? 1 : (m_mode == 0) ? 2 * m_per : m_per + 1;
                nph = (m_ph + 1) % len;
                cm  = (nph == 0) && m_pend;
            end else begin
                cm = en && m_mode == 3 && m_pend;
            end
            if (cm) begin
                m_mode = s_mode; m_per = s_per; m_pre = s_pre;
                m_pend = 0; m_pc = 0; m_upd = 1;
                if (m_mode != 3) begin
                    m_ph = 0; m_fresh = 1; derive();
                end
            end else if (tk) begin
                m_ph = nph; m_fresh = 0; m_pc = 0; derive();
            end else if (en && m_mode != 3) begin
                m_pc = m_pc + 1;
            end
            if (tk) begin
                m_zero = (m_count == 0);
                m_peak = (m_count == m_per);
            end
            if (load_i) begin
                s_mode = int'(mode_i); s_per = int'(period_i); s_pre = int'(prescale_i);
                m_pend = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (chk) begin
            vecs++;
            if (int'(count_o) != m_count || dir_o != m_dir || zero_o != m_zero ||
                peak_o != m_peak || update_o != m_upd) begin
                errs++;
                $display("FAIL model cyc %0d: dut cnt=%0d dir=%0b z=%0b p=%0b u=%0b, want cnt=%0d dir=%0b z=%0b p=%0b u=%0b",
                         cyc, count_o, dir_o, zero_o, peak_o, update_o,
                         m_count, m_dir, m_zero, m_peak, m_upd);
            end
        end
    endtask

    task automatic expect_lit(input string name, input int c, input bit d, input bit z,
                              input bit p, input bit u);
        vecs++;
        if (int'(count_o) != c || dir_o != d || zero_o != z || peak_o != p || update_o != u) begin
            errs++;
            $display("FAIL %s dut: cnt=%0d dir=%0b z=%0b p=%0b u=%0b, want cnt=%0d dir=%0b z=%0b p=%0b u=%0b",
                     name, count_o, dir_o, zero_o, peak_o, update_o, c, d, z, p, u);
        end
        vecs++;
        if (m_count != c || m_dir != d || m_zero != z || m_peak != p || m_upd != u) begin
            errs++;
            $display("FAIL %s model: cnt=%0d dir=%0b z=%0b p=%0b u=%0b, want cnt=%0d dir=%0b z=%0b p=%0b u=%0b",
                     name, m_count, m_dir, m_zero, m_peak, m_upd, c, d, z, p, u);
        end
    endtask

    task automatic do_load(input int md, input int per, input int pre);
        load_i = 1'b1; mode_i = 2'(md); period_i = N'(per); prescale_i = P'(pre);
        step();
        load_i = 1'b0;
    endtask

    task automatic wait_upd(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = update_o;
        end
        if (!seen) begin
            vecs++; errs++;
            $display("FAIL %s: update_o=0 after 100 cycles, want a commit", name);
        end
    endtask

    initial begin : stim
        int seq_up[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        int dn[4] = '{2, 1, 0, 3};

        step(); step();
        chk = 1'b1;
        expect_lit("reset", 0, 1, 0, 0, 0);

        // Default triangle, PER 15
        nrst = 1'b1; en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 15) expect_lit("tri_peak", 15, 1, 0, 1, 0);
            if (i == 30) expect_lit("tri_zero", 0, 0, 1, 0, 0);
        end

        // Switch to saw up PER 5 while rising through 7
        for (int i = 0; i < 7; i++) step();
        expect_lit("tri_at7", 7, 1, 0, 0, 0);
        do_load(1, 5, 0);
        wait_upd("commit_saw5");
        expect_lit("commit_saw5", 0, 1, 1, 0, 1);
        for (int j = 1; j <= 6; j++) begin
            step();
            expect_lit("saw5_seq", j % 6, 1, j == 6, j == 5, 0);
        end

        // Prescale 2, saw up PER 3, with a 4-cycle enable gap
        do_load(1, 3, 2);
        wait_upd("commit_pre2");
        expect_lit("commit_pre2", 0, 1, 1, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            expect_lit("pre2_seq", seq_up[i-1], 1, i == 12, i == 9, 0);
            if (i == 4) begin
                en = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    step();
                    expect_lit("en_gap", 1, 1, 0, 0, 0);
                end
                en = 1'b1;
            end
        end

        // Saw down PER 3
        do_load(2, 3, 0);
        wait_upd("commit_down3");
        expect_lit("commit_down3", 3, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_lit("down3_seq", dn[i], 0, dn[i] == 0, dn[i] == 3, 0);
        end

        // PER 0 triangle
        do_load(0, 0, 0);
        wait_upd("commit_per0");
        expect_lit("commit_per0", 0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_lit("per0_seq", 0, 1, 1, 1, 0);
        end

        // Two loads before a boundary: only the second commits
        en = 1'b0;
        do_load(1, 7, 0);
        do_load(1, 9, 0);
        en = 1'b1;
        step();
        expect_lit("second_load", 0, 1, 1, 0, 1);
        for (int i = 1; i <= 9; i++) step();
        expect_lit("per9_peak", 9, 1, 0, 1, 0);
        step(); step(); step();
        nrst = 1'b0;
        step();
        expect_lit("mid_reset", 0, 1, 0, 0, 0);
        nrst = 1'b1;
        for (int i = 0; i < 15; i++) step();
        expect_lit("defaults_back", 15, 1, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(9) < 8);
            load_i     = ($urandom_range(19) == 0);
            mode_i     = 2'($urandom_range(3));
            period_i   = ($urandom_range(3) == 0) ? N'($urandom_range(1)) : N'($urandom_range(PMAX));
            prescale_i = P'($urandom_range(2));
            nrst       = ($urandom_range(499) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
